ecc_61_wr_enc: RTL and testbench

//  Write-side SECDED encoder for the 61-bit FIFO datapath. Accepts data words over a valid/ready

---
 rtl/ecc_61_pkg.sv | 25 ++
 rtl/ecc_61_skid.sv | 46 ++++
 rtl/ecc_61_wr_enc.sv | 92 +++++++++
 tb/tb_ecc_61_wr_enc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ecc_61_pkg.sv
// ecc_61_pkg: shared SECDED(69,61) definitions for the write-side encoder and read-side checker.
package ecc_61_pkg;
    localparam int DATA_W = 61;
    localparam int PAR_W  = 8;
    localparam int CW_W   = 69;
    typedef logic [68:0] ecc61_cw_t;
    // Column j is the j-th integer >= 3 that is not a power of two.
    localparam logic [6:0] COL_CODE [DATA_W] = '{
        7'd3,  7'd5,  7'd6,  7'd7,  7'd9,  7'd10, 7'd11, 7'd12, 7'd13, 7'd14,
        7'd15, 7'd17, 7'd18, 7'd19, 7'd20, 7'd21, 7'd22, 7'd23, 7'd24, 7'd25,
        7'd26, 7'd27, 7'd28, 7'd29, 7'd30, 7'd31, 7'd33, 7'd34, 7'd35, 7'd36,
        7'd37, 7'd38, 7'd39, 7'd40, 7'd41, 7'd42, 7'd43, 7'd44, 7'd45, 7'd46,
        7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52, 7'd53, 7'd54, 7'd55, 7'd56,
        7'd57, 7'd58, 7'd59, 7'd60, 7'd61, 7'd62, 7'd63, 7'd65, 7'd66, 7'd67,
        7'd68
    };
    // p[7] tops up each column to odd weight so single and double errors are distinguishable.
    function automatic logic [PAR_W-1:0] ecc61_encode(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p = '0;
        for (int j = 0; j < DATA_W; j++)
            if (d[j]) p ^= {~^COL_CODE[j], COL_CODE[j]};
        return p;
    endfunction
endpackage

// File: rtl/ecc_61_skid.sv
// ecc_61_skid: generic valid/ready register stage with a 1-entry skid buffer.
// in_ready is registered (!skid_full) so there is no combinational path from out_ready.
module ecc_61_skid
    import ecc_61_pkg::*;
#(
    parameter int W = CW_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         out_valid_q, out_valid_d, skid_full_q, skid_full_d, out_free, in_xfer;
    logic [W-1:0] out_q, out_d, skid_q, skid_d;

    always_comb begin
        out_free    = !out_valid_q | out_ready;
        in_xfer     = in_valid & !skid_full_q;
        out_valid_d = out_free ? (skid_full_q | in_xfer) : out_valid_q;
        out_d       = !out_free ? out_q : skid_full_q ? skid_q : in_xfer ? in_data : out_q;
        skid_full_d = out_free ? 1'b0 : (skid_full_q | in_xfer);
        skid_d      = (!out_free & in_xfer) ? in_data : skid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready  = !skid_full_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;
endmodule

// File: rtl/ecc_61_wr_enc.sv
// ecc_61_wr_enc: write-side SECDED encoder, registered {parity,data} toward the FIFO RAM.
// Optional error injection enabled by defining ECC_61_ERR_INJ_EN.
module ecc_61_wr_enc
    import ecc_61_pkg::*;
#(
    parameter int DATA_WIDTH   = 61,
    parameter int PARITY_WIDTH = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_parity,
    output logic [CNT_WIDTH-1:0]    word_cnt
`ifdef ECC_61_ERR_INJ_EN
    ,
    input  logic                    inj_req,
    input  logic                    inj_dbl,
    input  logic [5:0]              inj_pos,
    output logic                    inj_done
`endif
);
    logic                  in_xfer;
    logic [DATA_WIDTH-1:0] flip;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    ecc61_cw_t             cw, cw_out;

    assign in_xfer = in_valid & in_ready;

`ifdef ECC_61_ERR_INJ_EN
    logic                  arm_q, arm_d, tag_skid_q, tag_skid_d, done_q, done_d;
    logic                  in_tag, out_free;
    logic [DATA_WIDTH-1:0] m;

    // The injection tag follows its word through the skid so inj_done marks its output load.
    always_comb begin
        m          = (inj_pos < 6'd61) ? (DATA_WIDTH'(1) << inj_pos) : '0;
        in_tag     = in_xfer & (arm_q | inj_req);
        flip       = in_tag ? (m | (inj_dbl ? {m[59:0], m[60]} : '0)) : '0;
        arm_d      = !in_xfer & (arm_q | inj_req);
        out_free   = !out_valid | out_ready;
        tag_skid_d = out_free ? 1'b0 : (in_xfer ? in_tag : tag_skid_q);
        done_d     = out_free & (in_ready ? in_tag : tag_skid_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arm_q      <= 1'b0;
            tag_skid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            arm_q      <= arm_d;
            tag_skid_q <= tag_skid_d;
            done_q     <= done_d;
        end
    end

    assign inj_done = done_q;
`else
    assign flip = '0;
`endif

    always_comb begin
        cw    = {ecc61_encode(in_data), in_data ^ flip};
        cnt_d = cnt_q + CNT_WIDTH'(in_xfer);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    ecc_61_skid #(.W(CW_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (cw_out)
    );

    assign out_data   = cw_out[DATA_WIDTH-1:0];
    assign out_parity = cw_out[CW_W-1:DATA_WIDTH];
    assign word_cnt   = cnt_q;
endmodule

// File: tb/tb_ecc_61_wr_enc.sv
// tb_ecc_61_wr_enc: randomized bench for ecc_61_wr_enc with a queue scoreboard and SECDED reference.
module tb_ecc_61_wr_enc;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [60:0] in_data = '0, out_data;
    logic [7:0]  out_parity;
    logic [15:0] word_cnt;
`ifdef ECC_61_ERR_INJ_EN
    logic        inj_req = 1'b0, inj_dbl = 1'b0, inj_done;
    logic [5:0]  inj_pos = '0;
`endif

    int          checks = 0, failures = 0, st, pos;
    int          col[61];
    logic [68:0] q[$];
    logic [15:0] exp_cnt = '0;
    logic        hold_pend = 1'b0;
    logic [68:0] hold_val;
    logic [60:0] vd[5], dw;
    logic [7:0]  vp[5];

    always #5 clk = ~clk;

    ecc_61_wr_enc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .word_cnt(word_cnt)
`ifdef ECC_61_ERR_INJ_EN
        , .inj_req(inj_req), .inj_dbl(inj_dbl), .inj_pos(inj_pos), .inj_done(inj_done)
`endif
    );

    function automatic logic [7:0] ref_par(logic [60:0] d);
        logic [6:0] x = '0;
        logic       e = 1'b0;
        for (int j = 0; j < 61; j++)
            if (d[j]) begin
                x ^= 7'(col[j]);
                e ^= ($countones(col[j]) % 2 == 0);
            end
        return {e, x};
    endfunction

    // 0 clean, 1 single-bit (p = data bit or -1 for a check bit), 2 double-bit
    function automatic int decode(logic [60:0] d, logic [7:0] p, output int bp);
        logic [7:0] s = ref_par(d) ^ p;
        bp = -1;
        if (s == 8'h00) return 0;
        if ($countones(s) % 2 == 0) return 2;
        for (int j = 0; j < 61; j++)
            if (ref_par(61'(1) << j) == s) bp = j;
        return 1;
    endfunction

    task automatic chk(string tag, logic [68:0] got, logic [68:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [60:0] rnd();
        return 61'({$urandom(), $urandom()});
    endfunction

    task automatic cycle(logic v, logic [60:0] d, logic r);
        logic [68:0] e;
        int          bp;
        in_valid = v; in_data = d; out_ready = r;
        if (hold_pend) chk("hold", {out_parity, out_data}, hold_val);
        hold_pend = out_valid && !r;
        hold_val  = {out_parity, out_data};
        if (out_valid && r) begin
            if (q.size() == 0) chk("spurious", 1, 0);
            else begin
                e = q.pop_front();
                chk("out", {out_parity, out_data}, e);
                chk("dec", 69'(decode(out_data, out_parity, bp)), 0);
            end
        end
        if (v && in_ready) begin
            q.push_back({ref_par(d), d});
            exp_cnt++;
        end
        @(posedge clk); #1;
        chk("cnt", 69'(word_cnt), 69'(exp_cnt));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        begin
            int n = 0;
            for (int v = 3; n < 61; v++) if ((v & (v - 1)) != 0) col[n++] = v;
        end
        vd[0] = '0;            vp[0] = 8'h00;
        vd[1] = 61'h1;         vp[1] = 8'h83;
        vd[2] = 61'h2;         vp[2] = 8'h85;
        vd[3] = 61'(1) << 57;  vp[3] = 8'hC1;
        vd[4] = 61'(1) << 60;  vp[4] = 8'hC4;

        #2;
        chk("rst_valid", 69'(out_valid), 0);
        chk("rst_ready", 69'(in_ready), 1);
        chk("rst_cw", {out_parity, out_data}, 0);
        chk("rst_cnt", 69'(word_cnt), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vd[i], 1'b1);
            chk("lat_valid", 69'(out_valid), 1);
            chk("vec_par", 69'(out_parity), 69'(vp[i]));
            chk("vec_data", 69'(out_data), 69'(vd[i]));
            cycle(1'b0, '0, 1'b1);
            chk("vec_idle", 69'(out_valid), 0);
        end

        for (int i = 0; i < 200; i++) begin
            if (i > 0) chk("stream_valid", 69'(out_valid), 1);
            cycle(1'b1, rnd(), 1'b1);
        end

        cycle(1'b1, rnd(), 1'b0);
        chk("bp_ready", 69'(in_ready), 0);
        cycle(1'b1, rnd(), 1'b0);
        cycle(1'b1, rnd(), 1'b0);
        chk("bp_ready2", 69'(in_ready), 0);
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd(), 1'b1);

        for (int i = 0; i < 400; i++) cycle($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0);
        for (int i = 0; i < 8 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
        chk("drain", 69'(q.size()), 0);
        chk("drain_idle", 69'(out_valid), 0);

        cycle(1'b1, rnd(), 1'b0);
        cycle(1'b1, rnd(), 1'b0);
        chk("held2_ready", 69'(in_ready), 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid", 69'(out_valid), 0);
        chk("arst_ready", 69'(in_ready), 1);
        chk("arst_cnt", 69'(word_cnt), 0);
        q.delete(); exp_cnt = '0; hold_pend = 1'b0;
        @(negedge clk); rst = 1'b0;
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("no_stale", 69'(out_valid), 0);

`ifdef ECC_61_ERR_INJ_EN
        dw = rnd();
        inj_pos = 6'd5; inj_dbl = 1'b0; inj_req = 1'b1; in_valid = 1'b1; in_data = dw; out_ready = 1'b1;
        @(posedge clk); #1;
        inj_req = 1'b0; in_valid = 1'b0; exp_cnt++;
        chk("inj_done", 69'(inj_done), 1);
        st = decode(out_data, out_parity, pos);
        chk("inj_sbe", 69'(st), 1);
        chk("inj_pos", 69'(pos), 5);
        chk("inj_par", 69'(out_parity), 69'(ref_par(dw)));
        chk("inj_fix", 69'(out_data ^ (61'(1) << 5)), 69'(dw));
        @(posedge clk); #1;
        chk("inj_once", 69'(inj_done), 0);
        dw = rnd(); in_valid = 1'b1; in_data = dw;
        @(posedge clk); #1;
        in_valid = 1'b0; exp_cnt++;
        chk("inj_clean", 69'(decode(out_data, out_parity, pos)), 0);
        chk("inj_clean_d", 69'(out_data), 69'(dw));
        chk("inj_clean_done", 69'(inj_done), 0);
        inj_dbl = 1'b1; inj_req = 1'b1;
        @(posedge clk); #1;
        inj_req = 1'b0; dw = rnd(); in_valid = 1'b1; in_data = dw;
        @(posedge clk); #1;
        in_valid = 1'b0; exp_cnt++;
        chk("inj_dbl_done", 69'(inj_done), 1);
        chk("inj_dbe", 69'(decode(out_data, out_parity, pos)), 2);
        chk("inj_dbl_d", 69'(out_data ^ (61'(3) << 5)), 69'(dw));
        @(posedge clk); #1;
        inj_dbl = 1'b0;
        chk("inj_cnt", 69'(word_cnt), 69'(exp_cnt));
`endif

        for (int i = 0; i < 70000 && exp_cnt != 16'hFFFE; i++) cycle(1'b1, rnd(), 1'b1);
        chk("wrap_pre", 69'(word_cnt), 69'h0FFFE);
        cycle(1'b1, rnd(), 1'b1);
        chk("wrap_ffff", 69'(word_cnt), 69'h0FFFF);
        cycle(1'b1, rnd(), 1'b1);
        chk("wrap_zero", 69'(word_cnt), 69'h00000);
        for (int i = 0; i < 8 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
        chk("final_drain", 69'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
